// File: rtl/sram_ctrl_pkg.sv
// Shared types and timing defaults for the asynchronous SRAM controller.
// Holds the access-phase enum, the request record and the wait-state counter reload helper.
package sram_ctrl_pkg;

    localparam int SRAM_DW       = 16;
    localparam int SRAM_T_SETUP  = 1;
    localparam int SRAM_T_ACCESS = 3;
    localparam int SRAM_T_HOLD   = 1;
    localparam int SRAM_CNT_W    = 8;

    localparam logic [SRAM_CNT_W-1:0] CNT_ZERO = {SRAM_CNT_W{1'b0}};
    localparam logic [SRAM_CNT_W-1:0] CNT_ONE  = SRAM_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } sram_state_e;

    typedef struct packed {
        logic               is_read;
        logic [15:0]        addr;
        logic [SRAM_DW-1:0] wdata;
    } sram_req_t;

    function automatic logic [SRAM_CNT_W-1:0] reload_cnt(input int t);
        reload_cnt = SRAM_CNT_W'(t - 1);
    endfunction

endpackage

// File: rtl/sram_async_ctrl.sv
// Single-clock controller that turns read/write request pulses into timed CE/OE/WE strobes
// for a 16-bit asynchronous SRAM, with a one-entry pending slot and programmable wait states.
module sram_async_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int T_SETUP  = SRAM_T_SETUP,
    parameter int T_ACCESS = SRAM_T_ACCESS,
    parameter int T_HOLD   = SRAM_T_HOLD
) (
    input  logic               s_clk,
    input  logic               s_rst_n,
    input  logic               s_req,
    input  logic               s_wr_req,
    input  logic               s_rd_req,
    input  logic [15:0]        s_addr,
    input  logic [SRAM_DW-1:0] s_wdata,
    output logic [SRAM_DW-1:0] s_rdata,
    output logic               s_valid,
    output logic               s_busy,
    output logic               s_ovf,
    output logic               bus_own,
    output logic [ADDR_W-1:0]  sram_a,
    output logic [SRAM_DW-1:0] sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    sram_state_e              state_q, state_d;
    logic [SRAM_CNT_W-1:0]    cnt_q, cnt_d;
    sram_req_t                slot_q, slot_d;
    logic                     slot_full_q, slot_full_d;
    sram_req_t                act_q, act_d;

    logic [SRAM_DW-1:0]       s_rdata_q, rdata_d;
    logic                     s_valid_q, valid_d;
    logic                     s_busy_q, busy_d;
    logic                     s_ovf_q, ovf_d;
    logic                     bus_own_q, bus_own_d;
    logic [ADDR_W-1:0]        sram_a_q, sram_a_d;
    logic [SRAM_DW-1:0]       sram_dq_o_q, dq_o_d;
    logic                     sram_dq_oe_q, dq_oe_d;
    logic                     sram_ce_n_q, ce_n_d;
    logic                     sram_oe_n_q, oe_n_d;
    logic                     sram_we_n_q, we_n_d;

    logic                     new_req_s;
    logic                     drive_s;
    logic                     strobe_s;

    // Next-state, pending-slot and pin values; pins are computed from the next state so they are registered.
    always_comb begin
        new_req_s   = s_rd_req | s_wr_req;
        state_d     = state_q;
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        slot_full_d = slot_full_q;
        act_d       = act_q;
        rdata_d     = s_rdata_q;
        ovf_d       = s_ovf_q | (new_req_s & slot_full_q);

        // A simultaneous read and write pulse is recorded as a read.
        if (new_req_s) begin
            slot_d      = '{is_read: s_rd_req, addr: s_addr, wdata: s_wdata};
            slot_full_d = 1'b1;
        end else begin
            slot_full_d = slot_full_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (s_req && slot_full_d) begin
                    state_d     = ST_SETUP;
                    cnt_d       = reload_cnt(T_SETUP);
                    act_d       = slot_d;
                    slot_full_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_ACCESS;
                    cnt_d   = reload_cnt(T_ACCESS);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_HOLD;
                    cnt_d   = reload_cnt(T_HOLD);
                    if (act_q.is_read) begin
                        rdata_d = sram_dq_i;
                    end else begin
                        rdata_d = s_rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_DONE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        drive_s   = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
        strobe_s  = (state_d == ST_ACCESS);
        ce_n_d    = ~drive_s;
        oe_n_d    = ~(strobe_s & act_d.is_read);
        we_n_d    = ~(strobe_s & ~act_d.is_read);
        dq_oe_d   = drive_s & ~act_d.is_read;
        valid_d   = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE) | slot_full_d;
        bus_own_d = s_req | (state_d != ST_IDLE);
        sram_a_d  = act_d.addr[ADDR_W-1:0];

        // Reads leave the last write data on the pad register; the pad driver is off anyway.
        if (act_d.is_read) begin
            dq_o_d = sram_dq_o_q;
        end else begin
            dq_o_d = act_d.wdata;
        end
    end

    // State, slot, active access and all output registers; reset returns every strobe high at once.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            slot_q       <= '0;
            slot_full_q  <= 1'b0;
            act_q        <= '0;
            s_rdata_q    <= {SRAM_DW{1'b0}};
            s_valid_q    <= 1'b0;
            s_busy_q     <= 1'b0;
            s_ovf_q      <= 1'b0;
            bus_own_q    <= 1'b0;
            sram_a_q     <= {ADDR_W{1'b0}};
            sram_dq_o_q  <= {SRAM_DW{1'b0}};
            sram_dq_oe_q <= 1'b0;
            sram_ce_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            sram_we_n_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            slot_full_q  <= slot_full_d;
            act_q        <= act_d;
            s_rdata_q    <= rdata_d;
            s_valid_q    <= valid_d;
            s_busy_q     <= busy_d;
            s_ovf_q      <= ovf_d;
            bus_own_q    <= bus_own_d;
            sram_a_q     <= sram_a_d;
            sram_dq_o_q  <= dq_o_d;
            sram_dq_oe_q <= dq_oe_d;
            sram_ce_n_q  <= ce_n_d;
            sram_oe_n_q  <= oe_n_d;
            sram_we_n_q  <= we_n_d;
        end
    end

    assign s_rdata    = s_rdata_q;
    assign s_valid    = s_valid_q;
    assign s_busy     = s_busy_q;
    assign s_ovf      = s_ovf_q;
    assign bus_own    = bus_own_q;
    assign sram_a     = sram_a_q;
    assign sram_dq_o  = sram_dq_o_q;
    assign sram_dq_oe = sram_dq_oe_q;
    assign sram_ce_n  = sram_ce_n_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign sram_we_n  = sram_we_n_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: directed scenarios plus random traffic, compared every cycle
// against a timeline model (access start cycle + offset arithmetic) and a small SRAM array.
module tb_sram_async_ctrl;
    import sram_ctrl_pkg::*;

    localparam int TS  = 1;
    localparam int TA  = 3;
    localparam int TH  = 1;
    localparam int LEN = TS + TA + TH + 1;

    logic        s_clk = 1'b0;
    logic        s_rst_n;
    logic        s_req, s_wr_req, s_rd_req;
    logic [15:0] s_addr, s_wdata, s_rdata;
    logic        s_valid, s_busy, s_ovf, bus_own;
    logic [15:0] sram_a, sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic [15:0] sram_mem [256];
    logic [15:0] m_mem    [256];

    int n_checks = 0;
    int n_errors = 0;

    // timeline model
    int          cyc, m_start;
    logic        m_act, m_rd, m_sreq, m_ovf;
    logic [15:0] m_addr, m_wdata, m_a, m_dqo, m_rdata;
    logic        m_slot_full, m_slot_rd;
    logic [15:0] m_slot_addr, m_slot_wdata;

    int          mon_we, mon_oe, mon_ce, mon_dqoe, mon_valid;
    logic [15:0] mon_a, mon_d;

    always #5 s_clk = ~s_clk;

    assign sram_dq_i = sram_oe_n ? 16'h0000 : sram_mem[sram_a[7:0]];

    sram_async_ctrl #(.ADDR_W(16), .T_SETUP(TS), .T_ACCESS(TA), .T_HOLD(TH)) dut (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .s_req(s_req), .s_wr_req(s_wr_req),
        .s_rd_req(s_rd_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_valid(s_valid), .s_busy(s_busy), .s_ovf(s_ovf), .bus_own(bus_own),
        .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    function automatic logic [15:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        pat = {b, ~b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_start = 0; m_act = 1'b0; m_rd = 1'b0; m_sreq = 1'b0; m_ovf = 1'b0;
        m_addr = 16'h0000; m_wdata = 16'h0000; m_a = 16'h0000; m_dqo = 16'h0000;
        m_rdata = 16'h0000; m_slot_full = 1'b0; m_slot_rd = 1'b0;
        m_slot_addr = 16'h0000; m_slot_wdata = 16'h0000;
    endtask

    // one clock edge of the reference: retire/capture, record request, start if bus granted
    task automatic model_step();
        int prev;
        cyc++;
        m_sreq = s_req;
        if (m_act) begin
            prev = cyc - 1 - m_start;
            if (m_rd && prev == TS + TA - 1) m_rdata = m_mem[m_addr[7:0]];
            if (prev == LEN - 1) m_act = 1'b0;
        end
        if (s_rd_req || s_wr_req) begin
            if (m_slot_full) m_ovf = 1'b1;
            m_slot_full = 1'b1; m_slot_rd = s_rd_req;
            m_slot_addr = s_addr; m_slot_wdata = s_wdata;
        end
        if (!m_act && s_req && m_slot_full) begin
            m_act = 1'b1; m_start = cyc; m_rd = m_slot_rd;
            m_addr = m_slot_addr; m_wdata = m_slot_wdata; m_slot_full = 1'b0;
            m_a = m_addr;
            if (!m_rd) begin
                m_dqo = m_wdata;
                m_mem[m_addr[7:0]] = m_wdata;
            end
        end
    endtask

    task automatic compare_all();
        int   o;
        logic drv, acc, dn;
        o   = cyc - m_start;
        drv = m_act && (o < TS + TA + TH);
        acc = m_act && (o >= TS) && (o < TS + TA);
        dn  = m_act && (o == LEN - 1);
        chk("ce_n",    32'(sram_ce_n),  32'(!drv));
        chk("oe_n",    32'(sram_oe_n),  32'(!(acc && m_rd)));
        chk("we_n",    32'(sram_we_n),  32'(!(acc && !m_rd)));
        chk("dq_oe",   32'(sram_dq_oe), 32'(drv && !m_rd));
        chk("valid",   32'(s_valid),    32'(dn));
        chk("busy",    32'(s_busy),     32'(m_act || m_slot_full));
        chk("ovf",     32'(s_ovf),      32'(m_ovf));
        chk("bus_own", 32'(bus_own),    32'(m_sreq || m_act));
        chk("addr",    32'(sram_a),     32'(m_a));
        chk("dq_o",    32'(sram_dq_o),  32'(m_dqo));
        chk("rdata",   32'(s_rdata),    32'(m_rdata));
    endtask

    task automatic mon_reset();
        mon_we = 0; mon_oe = 0; mon_ce = 0; mon_dqoe = 0; mon_valid = 0;
        mon_a = 16'h0000; mon_d = 16'h0000;
    endtask

    task automatic tick();
        @(posedge s_clk);
        model_step();
        @(negedge s_clk);
        if (!sram_we_n) begin
            sram_mem[sram_a[7:0]] = sram_dq_o;
            mon_we++; mon_a = sram_a; mon_d = sram_dq_o;
        end
        if (!sram_oe_n) mon_oe++;
        if (!sram_ce_n) mon_ce++;
        if (sram_dq_oe) mon_dqoe++;
        if (s_valid)    mon_valid++;
        compare_all();
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        s_rd_req = rd; s_wr_req = wr; s_addr = a; s_wdata = d;
        tick();
        s_rd_req = 1'b0; s_wr_req = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_valid && n < 40);
        chk("valid_timeout", 32'(s_valid), 32'd1);
    endtask

    initial begin
        int n, r;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = pat(i);
            m_mem[i]    = pat(i);
        end
        s_rst_n = 1'b1; s_req = 1'b0; s_rd_req = 1'b0; s_wr_req = 1'b0;
        s_addr = 16'h0000; s_wdata = 16'h0000;
        model_reset(); mon_reset();
        #1 s_rst_n = 1'b0;
        @(negedge s_clk); @(negedge s_clk);
        chk("rst_rdata", 32'(s_rdata), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_busy",  32'(s_busy), 32'd0);
        chk("rst_ovf",   32'(s_ovf), 32'd0);
        chk("rst_own",   32'(bus_own), 32'd0);
        chk("rst_dqoe",  32'(sram_dq_oe), 32'd0);
        chk("rst_a",     32'(sram_a), 32'd0);
        chk("rst_dqo",   32'(sram_dq_o), 32'd0);
        chk("rst_ce",    32'(sram_ce_n), 32'd1);
        chk("rst_oe",    32'(sram_oe_n), 32'd1);
        chk("rst_we",    32'(sram_we_n), 32'd1);
        s_rst_n = 1'b1; s_req = 1'b1;
        model_reset();
        tick(); tick();

        // write 0xBEEF to 0x1234
        mon_reset();
        issue(1'b0, 1'b1, 16'h1234, 16'hBEEF);
        wait_valid(n);
        chk("wr_latency", 32'(1 + n), 32'd6);
        chk("wr_we_cycles", 32'(mon_we), 32'd3);
        chk("wr_addr", 32'(mon_a), 32'h1234);
        chk("wr_data", 32'(mon_d), 32'hBEEF);
        tick();

        // read it back
        mon_reset();
        issue(1'b1, 1'b0, 16'h1234, 16'h0000);
        wait_valid(n);
        chk("rd_latency", 32'(1 + n), 32'd6);
        chk("rd_data", 32'(s_rdata), 32'hBEEF);
        chk("rd_oe_cycles", 32'(mon_oe), 32'd3);
        chk("rd_no_dqoe", 32'(mon_dqoe), 32'd0);
        tick();

        // request held while the host does not own the bus
        s_req = 1'b0;
        tick();
        mon_reset();
        issue(1'b1, 1'b0, 16'h0042, 16'h0000);
        for (int i = 0; i < 9; i++) tick();
        chk("held_no_ce", 32'(mon_ce), 32'd0);
        chk("held_busy", 32'(s_busy), 32'd1);
        chk("held_own", 32'(bus_own), 32'd0);
        s_req = 1'b1;
        tick();
        chk("held_start", 32'(sram_ce_n), 32'd0);
        wait_valid(n);
        chk("held_latency", 32'(n), 32'd5);
        chk("held_rdata", 32'(s_rdata), 32'h42BD);
        tick();

        // two writes queued behind a read: the second overwrites the first
        mon_reset();
        issue(1'b1, 1'b0, 16'h0010, 16'h0000);
        issue(1'b0, 1'b1, 16'h0020, 16'h1111);
        issue(1'b0, 1'b1, 16'h0030, 16'h2222);
        wait_valid(n);
        chk("ovf_rdata", 32'(s_rdata), 32'h10EF);
        wait_valid(n);
        chk("ovf_flag", 32'(s_ovf), 32'd1);
        chk("ovf_we_cycles", 32'(mon_we), 32'd3);
        chk("ovf_addr", 32'(mon_a), 32'h0030);
        chk("ovf_data", 32'(mon_d), 32'h2222);
        tick();

        // read and write pulses together: read only
        mon_reset();
        issue(1'b1, 1'b1, 16'h1234, 16'h0BAD);
        wait_valid(n);
        chk("both_oe", 32'(mon_oe), 32'd3);
        chk("both_no_we", 32'(mon_we), 32'd0);
        chk("both_rdata", 32'(s_rdata), 32'hBEEF);
        tick();

        // bus ownership dropped during a write
        mon_reset();
        issue(1'b0, 1'b1, 16'h00A5, 16'h1357);
        s_req = 1'b0;
        wait_valid(n);
        chk("drop_latency", 32'(1 + n), 32'd6);
        chk("drop_we_cycles", 32'(mon_we), 32'd3);
        tick();
        chk("drop_own", 32'(bus_own), 32'd0);
        s_req = 1'b1;
        tick();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) s_req = ~s_req;
            r = $urandom_range(0, 9);
            s_rd_req = (r == 0) || (r == 2);
            s_wr_req = (r == 1) || (r == 2);
            s_addr   = 16'($urandom);
            s_wdata  = 16'($urandom);
            tick();
        end
        s_rd_req = 1'b0; s_wr_req = 1'b0; s_req = 1'b1;
        for (int k = 0; k < 60 && s_busy; k++) tick();
        chk("drain_idle", 32'(s_busy), 32'd0);

        // asynchronous reset while a write is in its strobe phase
        issue(1'b0, 1'b1, 16'h00FF, 16'h4321);
        tick();
        chk("rst_pre_we", 32'(sram_we_n), 32'd0);
        #2 s_rst_n = 1'b0;
        #1;
        chk("rst_async_we", 32'(sram_we_n), 32'd1);
        chk("rst_async_dqoe", 32'(sram_dq_oe), 32'd0);
        chk("rst_async_ce", 32'(sram_ce_n), 32'd1);
        @(posedge s_clk);
        @(negedge s_clk);
        s_rst_n = 1'b1;
        model_reset();
        mon_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("rst_no_valid", 32'(mon_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_async_ctrl.md
# sram_async_ctrl

Single-clock controller for the board's 16-bit asynchronous SRAM, on the fast side of the UART/SRAM clock-domain crossing. It turns one-cycle read and write request pulses into correctly timed chip-enable, output-enable and write-enable strobes with programmable wait states. It returns a one-cycle `s_valid` pulse, with read data, when each access completes; the crossing uses this pulse to end both read and write transactions. The SRAM pins are driven only while `s_req` (host owns memory) is high.

## Interface
Parameters:
- `ADDR_W`, 16: SRAM address width; `sram_a` = `s_addr[ADDR_W-1:0]`.
- `T_SETUP`, 1: cycles from address/CE valid to strobe assertion (≥1).
- `T_ACCESS`, 3: cycles the OE/WE strobe is held low (≥1).
- `T_HOLD`, 1: cycles address/data are held after the strobe rises (≥1).

Ports:
- `s_clk`, in, 1: the single clock.
- `s_rst_n`, in, 1: asynchronous, active-low reset.
- `s_req`, in, 1: level; host owns the SRAM bus.
- `s_wr_req`, in, 1: write request pulse.
- `s_rd_req`, in, 1: read request pulse.
- `s_addr`, in, 16: request address, sampled with the pulse.
- `s_wdata`, in, 16: write data, sampled with the pulse.
- `s_rdata`, out, 16: read data, valid while `s_valid` is high and held afterwards.
- `s_valid`, out, 1: one-cycle completion pulse for reads and writes.
- `s_busy`, out, 1: high while an access or pending request exists.
- `s_ovf`, out, 1: sticky flag, set when a pending request is overwritten; cleared only by reset.
- `bus_own`, out, 1: registered copy of `s_req` gated by FSM; enables external bus buffers.
- `sram_a`, out, ADDR_W: SRAM address.
- `sram_dq_o`, out, 16: write data to pad.
- `sram_dq_oe`, out, 1: pad output enable.
- `sram_dq_i`, in, 16: pad input data.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, out, 1 each: active-low strobes.

## Operation
- Reset values:
  - `s_rdata`, `sram_a` and `sram_dq_o` are 0.
  - `s_valid`, `s_busy`, `s_ovf`, `bus_own` and `sram_dq_oe` are 0.
  - All `_n` strobes are 1.
  - FSM is IDLE and the pending slot is empty.
- Request capture:
  - A pulse on `s_rd_req` or `s_wr_req` latches `{is_read, addr, wdata}` into the one-entry pending slot.
  - If both pulses are high in the same cycle, it is a read; the write is dropped.
  - A new pulse while the slot is already full overwrites the slot and sets `s_ovf`.
- FSM states: IDLE, SETUP, ACCESS, HOLD, DONE. A down-counter is reloaded on each state entry with `T_x - 1`.
- IDLE:
  - Goes to SETUP when the slot is full and `s_req` is high.
  - On the transition the slot contents move into the active registers and the slot empties.
  - While `s_req` is low, pending requests wait and all pins are idle (`bus_own` = 0, `sram_dq_oe` = 0).
- SETUP:
  - `sram_ce_n` = 0 and `sram_a` is driven.
  - For writes, `sram_dq_oe` = 1 and `sram_dq_o` = wdata.
  - Lasts `T_SETUP` cycles, then goes to ACCESS.
- ACCESS:
  - Read: `sram_oe_n` = 0. Write: `sram_we_n` = 0.
  - Lasts `T_ACCESS` cycles.
  - For reads, `sram_dq_i` is captured into `s_rdata` on the edge that leaves ACCESS.
- HOLD:
  - Strobes return high; `sram_ce_n`, `sram_a` and write data are held.
  - Lasts `T_HOLD` cycles, then goes to DONE.
- DONE:
  - One cycle with `s_valid` = 1 and `sram_ce_n` = 1, then back to IDLE.
- `s_req` falling during an access: the access completes unchanged, so writes are never truncated. `bus_own` drops in the cycle after DONE.
- `s_busy` = (state ≠ IDLE) or slot full.

## Timing
- A request pulse sampled at edge E0 gives SETUP in the cycle after E0.
- `s_valid` is high in cycle E0 + `T_SETUP` + `T_ACCESS` + `T_HOLD` + 1. With defaults this is 6 cycles after the request.
- Back-to-back accesses: the next SETUP may begin in the cycle after DONE. Minimum spacing is `T_SETUP` + `T_ACCESS` + `T_HOLD` + 1 cycles.
- All outputs are registered, with no combinational path from inputs to pins.
- `sram_we_n` and `sram_oe_n` are never low simultaneously. `sram_dq_oe` is never 1 while `sram_oe_n` = 0.
- Asynchronous reset mid-access deasserts all strobes and `sram_dq_oe` immediately; the in-flight access is lost and no `s_valid` is produced.
- `s_req` is used as already synchronised; this block adds no synchronisers.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the FSM state enum (IDLE, SETUP, ACCESS, HOLD, DONE);
  - default timing constants `SRAM_T_SETUP`, `SRAM_T_ACCESS`, `SRAM_T_HOLD`;
  - data width constant `SRAM_DW` = 16.
- Single module with no sub-modules. The wait-state counter is too small to split out.
- The top level instantiates the IOBUF from `sram_dq_o`, `sram_dq_oe` and `sram_dq_i`.

## Test plan
- Write: `s_req`=1, write pulse with addr 0x1234, data 0xBEEF.
  - Required: `sram_we_n` low for exactly 3 cycles with `sram_a`=0x1234 and `sram_dq_o`=0xBEEF.
  - Required: `s_valid` 6 cycles after the pulse.
- Read: SRAM model returns 0xBEEF for 0x1234; read pulse at 0x1234.
  - Required: `s_rdata`=0xBEEF with `s_valid` at cycle +6; `sram_dq_oe` stays 0 throughout.
- Held request: `s_req`=0, read pulse.
  - Required: no strobe activity and `s_busy`=1.
  - Raise `s_req` 10 cycles later. Required: access starts the next cycle and `s_valid` follows 5 cycles after that.
- Overwrite: issue a write during an active read, then a second write before the first write starts.
  - Required: only the second write is executed and `s_ovf`=1.
- Simultaneous and mid-access events:
  - `s_rd_req` and `s_wr_req` high in the same cycle. Required: a read only.
  - `s_req` dropped mid-write. Required: full `T_ACCESS` WE pulse and `s_valid` still produced.
- Reset mid-ACCESS: assert `s_rst_n`=0 while a write is in ACCESS.
  - Required: `sram_we_n`=1 and `sram_dq_oe`=0 in the same cycle, and no `s_valid` after release.
